// File: rtl/seq_timebase.sv
// Programmable free-running timebase for the step sequencer.
// Produces a count that wraps every active_period cycles, a tick at each
// wrap, and a step index for the pattern logic. New periods go into a shadow
// register first. While running, the shadow is applied only at a wrap, so a
// period is never cut short or stretched.
`timescale 1ns/1ps
module seq_timebase #(
    parameter int CNT_W          = 19,
    parameter int DEFAULT_PERIOD = 500000,
    parameter int MIN_PERIOD     = 2,
    parameter int STEPS          = 16,
    parameter int STEP_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              period_load,
    output logic              period_ack,
    output logic [CNT_W-1:0]  count_out,
    output logic              tick,
    output logic [STEP_W-1:0] step,
    output logic              step_wrap,
    output logic              running
);

    localparam logic [0:0]        ST_STOPPED = 1'b0;
    localparam logic [0:0]        ST_RUNNING = 1'b1;
    localparam logic [CNT_W-1:0]  DEFAULT_P  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0]  MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);

    // Requests below the minimum period are raised to it. A period of 2 is
    // the fastest one the counter can produce.
    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] r;
        if (p < MIN_P) begin
            r = MIN_P;
        end else begin
            r = p;
        end
        return r;
    endfunction

    logic [0:0]        state_r,        state_s;
    logic [CNT_W-1:0]  count_r,        count_s;
    logic [STEP_W-1:0] step_r,         step_s;
    logic              tick_r,         tick_s;
    logic              step_wrap_r,    step_wrap_s;
    logic              ack_r;
    logic [CNT_W-1:0]  active_r,       active_s;
    logic [CNT_W-1:0]  shadow_r,       shadow_s;
    logic              shadow_valid_r, shadow_valid_s;
    logic              at_last_s;

    // Next-state logic: run control, counting, step advance and period hand-over.
    always_comb begin
        state_s        = state_r;
        count_s        = count_r;
        step_s         = step_r;
        tick_s         = 1'b0;
        step_wrap_s    = 1'b0;
        active_s       = active_r;
        shadow_s       = shadow_r;
        shadow_valid_s = shadow_valid_r;
        at_last_s      = (count_r == (active_r - CNT_ONE));

        case (state_r)
            ST_STOPPED: begin
                count_s = CNT_ZERO;
                // A stopped timebase has no period in flight, so adopt at once.
                if (shadow_valid_r) begin
                    active_s       = shadow_r;
                    shadow_valid_s = 1'b0;
                end else begin
                    active_s       = active_r;
                end
                if (run) begin
                    state_s = ST_RUNNING;
                end else begin
                    state_s = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (!run) begin
                    state_s = ST_STOPPED;
                    count_s = CNT_ZERO;
                end else if (at_last_s) begin
                    count_s = CNT_ZERO;
                    tick_s  = 1'b1;
                    if (step_r == LAST_STEP) begin
                        step_s      = STEP_ZERO;
                        step_wrap_s = 1'b1;
                    end else begin
                        step_s      = step_r + STEP_ONE;
                        step_wrap_s = 1'b0;
                    end
                    // The wrap is the only glitch-free point for a period change.
                    if (shadow_valid_r) begin
                        active_s       = shadow_r;
                        shadow_valid_s = 1'b0;
                    end else begin
                        active_s       = active_r;
                    end
                end else begin
                    count_s = count_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_STOPPED;
                count_s = CNT_ZERO;
            end
        endcase

        // A fresh load always lands in the shadow. If it coincides with a wrap,
        // the wrap above used the previous shadow or active period.
        if (period_load) begin
            shadow_s       = clamp_period(period_in);
            shadow_valid_s = 1'b1;
        end else begin
            shadow_s       = shadow_s;
        end
    end

    // State and output registers; reset overrides everything, including loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_STOPPED;
            count_r        <= CNT_ZERO;
            step_r         <= STEP_ZERO;
            tick_r         <= 1'b0;
            step_wrap_r    <= 1'b0;
            ack_r          <= 1'b0;
            active_r       <= DEFAULT_P;
            shadow_r       <= DEFAULT_P;
            shadow_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            count_r        <= count_s;
            step_r         <= step_s;
            tick_r         <= tick_s;
            step_wrap_r    <= step_wrap_s;
            ack_r          <= period_load;
            active_r       <= active_s;
            shadow_r       <= shadow_s;
            shadow_valid_r <= shadow_valid_s;
        end
    end

    assign count_out  = count_r;
    assign tick       = tick_r;
    assign step       = step_r;
    assign step_wrap  = step_wrap_r;
    assign period_ack = ack_r;
    assign running    = (state_r == ST_RUNNING);

endmodule

// File: tb/tb_seq_timebase.sv
// Self-checking bench for seq_timebase: a behavioural model compared every
// cycle, directed scenarios with hand-computed expectations, random stimulus,
// and a narrow-width instance to exercise the all-ones period boundary.
`timescale 1ns/1ps
module tb_seq_timebase;

    localparam int CNT_W = 19;
    localparam int STEPS = 16;
    localparam int STEP_W = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic              rst, run, period_load;
    logic [CNT_W-1:0]  period_in;
    logic              period_ack, tick, step_wrap, running;
    logic [CNT_W-1:0]  count_out;
    logic [STEP_W-1:0] step;

    seq_timebase #(.CNT_W(CNT_W), .DEFAULT_PERIOD(500000), .MIN_PERIOD(2),
                   .STEPS(STEPS), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .run(run), .period_in(period_in),
        .period_load(period_load), .period_ack(period_ack),
        .count_out(count_out), .tick(tick), .step(step),
        .step_wrap(step_wrap), .running(running));

    // narrow instance: 8-bit count so the all-ones period fits in a short run
    logic       s_rst, s_run, s_load, s_ack, s_tick, s_wrap, s_running;
    logic [7:0] s_pin, s_count;
    logic [3:0] s_step;

    seq_timebase #(.CNT_W(8), .DEFAULT_PERIOD(200), .MIN_PERIOD(2),
                   .STEPS(16), .STEP_W(4)) dut_small (
        .clk(clk), .rst(s_rst), .run(s_run), .period_in(s_pin),
        .period_load(s_load), .period_ack(s_ack), .count_out(s_count),
        .tick(s_tick), .step(s_step), .step_wrap(s_wrap), .running(s_running));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_running = 1'b0, m_pend = 1'b0, m_tick = 1'b0, m_wrap = 1'b0, m_ack = 1'b0;
    int m_count = 0, m_step = 0, m_active = 500000, m_shadow = 500000;

    always @(posedge clk) begin
        if (rst) begin
            m_running = 1'b0; m_pend = 1'b0; m_tick = 1'b0; m_wrap = 1'b0; m_ack = 1'b0;
            m_count = 0; m_step = 0; m_active = 500000; m_shadow = 500000;
        end else begin
            m_tick = 1'b0;
            m_wrap = 1'b0;
            m_ack  = period_load;
            if (!m_running) begin
                if (m_pend) begin m_active = m_shadow; m_pend = 1'b0; end
                m_count   = 0;
                m_running = run;
            end else if (!run) begin
                m_running = 1'b0;
                m_count   = 0;
            end else if (m_count == m_active - 1) begin
                m_count = 0;
                m_tick  = 1'b1;
                m_step  = (m_step + 1) % STEPS;
                m_wrap  = (m_step == 0);
                if (m_pend) begin m_active = m_shadow; m_pend = 1'b0; end
            end else begin
                m_count = m_count + 1;
            end
            if (period_load) begin
                m_shadow = (period_in < 2) ? 2 : int'(period_in);
                m_pend   = 1'b1;
            end
        end
    end

    // compare process: outputs settle after posedge, sampled on negedge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model count_out", 32'(count_out), m_count);
            chk("model step", 32'(step), m_step);
            chk("model tick", 32'(tick), 32'(m_tick));
            chk("model step_wrap", 32'(step_wrap), 32'(m_wrap));
            chk("model period_ack", 32'(period_ack), 32'(m_ack));
            chk("model running", 32'(running), 32'(m_running));
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        period_in   = CNT_W'(v);
        period_load = 1'b1;
        cyc(1);
        period_load = 1'b0;
        chk("ack after load", 32'(period_ack), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; period_load = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin cyc(1); n++; end while (tick !== 1'b1 && n < budget);
        if (tick !== 1'b1) chk("tick timeout", 32'(tick), 1);
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (32'(count_out) != target && n < budget) begin cyc(1); n++; end
        chk("wait for count", 32'(count_out), target);
    endtask

    task automatic s_wait_tick(input int budget, output int n, output int maxc);
        n = 0; maxc = 0;
        do begin
            if (int'(s_count) > maxc) maxc = int'(s_count);
            cyc(1); n++;
        end while (s_tick !== 1'b1 && n < budget);
        if (s_tick !== 1'b1) chk("small tick timeout", 32'(s_tick), 1);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, maxc, nt, nw, wrap_at;
        rst = 1'b1; run = 1'b0; period_load = 1'b0; period_in = '0;
        s_rst = 1'b1; s_run = 1'b0; s_load = 1'b0; s_pin = 8'd0;
        cyc(1);
        chk_en = 1'b1;
        rst = 1'b0; s_rst = 1'b0;

        // 1: reset state, stopped for 10 cycles
        chk("reset count_out", 32'(count_out), 0);
        chk("reset step", 32'(step), 0);
        chk("reset running", 32'(running), 0);
        chk("reset ack", 32'(period_ack), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("stopped no tick", 32'(tick), 0);
            chk("stopped count", 32'(count_out), 0);
        end
        // default period is long: 20 running cycles later count is 20, no tick
        run = 1'b1; cyc(21);
        chk("default period count", 32'(count_out), 20);
        run = 1'b0; cyc(1);
        chk("stop clears count", 32'(count_out), 0);

        // 2: load 5 while stopped, then run
        load(5);
        cyc(1);
        chk("single ack", 32'(period_ack), 0);
        run = 1'b1; cyc(1);
        chk("entry running", 32'(running), 1);
        chk("entry count", 32'(count_out), 0);
        chk("entry no tick", 32'(tick), 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("p5 count", 32'(count_out), i % 5);
            chk("p5 tick", 32'(tick), (i % 5 == 0) ? 1 : 0);
            chk("p5 step", 32'(step), i / 5);
        end

        // 3: period 3 for 48 cycles -> 16 ticks, one step_wrap on the 16th
        do_reset();
        chk("rst count", 32'(count_out), 0);
        chk("rst step", 32'(step), 0);
        chk("rst tick", 32'(tick), 0);
        chk("rst wrap", 32'(step_wrap), 0);
        chk("rst ack", 32'(period_ack), 0);
        chk("rst running", 32'(running), 0);
        load(3);
        run = 1'b1; cyc(1);
        nt = 0; nw = 0; wrap_at = -1;
        for (int i = 1; i <= 48; i++) begin
            cyc(1);
            if (tick === 1'b1) nt++;
            if (step_wrap === 1'b1) begin nw++; wrap_at = i; end
        end
        chk("p3 tick count", 32'(nt), 16);
        chk("p3 wrap count", 32'(nw), 1);
        chk("p3 wrap cycle", 32'(wrap_at), 48);
        chk("p3 step back to 0", 32'(step), 0);

        // 4a: period 6, load 3 at count 2 -> finish the 6, then 3
        do_reset();
        load(6);
        run = 1'b1; cyc(1);
        wait_count(2, 10);
        load(3);
        cyc(1);
        chk("mid load single ack", 32'(period_ack), 0);
        wait_tick(20, n); chk("finish old period", 32'(n), 2);
        wait_tick(20, n); chk("new period 3", 32'(n), 3);
        wait_tick(20, n); chk("new period 3 again", 32'(n), 3);

        // 4b: load on the wrap edge -> one more 6, then 3
        do_reset();
        load(6);
        run = 1'b1; cyc(1);
        wait_count(5, 10);
        load(3);
        chk("wrap-edge tick", 32'(tick), 1);
        wait_tick(20, n); chk("wrap-edge keeps 6", 32'(n), 6);
        wait_tick(20, n); chk("wrap-edge then 3", 32'(n), 3);

        // 5: period_in 0 clamps to 2
        load(0);
        wait_tick(20, n);
        wait_tick(20, n); chk("clamp period 2", 32'(n), 2);
        wait_tick(20, n); chk("clamp period 2 again", 32'(n), 2);

        // 6: stop at count 3 step 7, restart, reset mid-period
        do_reset();
        load(5);
        run = 1'b1; cyc(1);
        n = 0;
        while (!(step == 4'd7 && count_out == 19'd3) && n < 100) begin cyc(1); n++; end
        chk("reach step7 count3", 32'(count_out), 3);
        run = 1'b0; cyc(1);
        chk("stop count", 32'(count_out), 0);
        chk("stop step holds", 32'(step), 7);
        chk("stop running", 32'(running), 0);
        chk("stop tick", 32'(tick), 0);
        cyc(2);
        chk("stopped step holds", 32'(step), 7);
        run = 1'b1; cyc(1);
        chk("restart count", 32'(count_out), 0);
        wait_tick(20, n); chk("restart full period", 32'(n), 5);
        chk("restart step", 32'(step), 8);
        cyc(2);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mid rst count", 32'(count_out), 0);
        chk("mid rst step", 32'(step), 0);
        chk("mid rst running", 32'(running), 0);
        chk("mid rst tick", 32'(tick), 0);

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            run         = ($urandom_range(0, 99) < 90);
            period_load = ($urandom_range(0, 9) == 0);
            period_in   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 3))
                                                      : CNT_W'($urandom_range(2, 12));
            cyc(1);
        end
        rst = 1'b0; run = 1'b0; period_load = 1'b0;

        // narrow instance: all-ones period 255 and clamp of 1
        s_pin = 8'hFF; s_load = 1'b1; cyc(1); s_load = 1'b0;
        chk("small ack", 32'(s_ack), 1);
        s_run = 1'b1; cyc(1);
        chk("small entry count", 32'(s_count), 0);
        s_wait_tick(300, n, maxc);
        chk("max period length", 32'(n), 255);
        chk("max period top count", 32'(maxc), 254);
        chk("max period wrap count", 32'(s_count), 0);
        s_pin = 8'd1; s_load = 1'b1; cyc(1); s_load = 1'b0;
        s_wait_tick(300, n, maxc);
        chk("max period before clamp", 32'(n), 254);
        s_wait_tick(20, n, maxc);
        chk("small clamp period", 32'(n), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_timebase.md
Name: seq_timebase

Overview:
- Programmable free-running timebase for the step sequencer.
- Produces the 19-bit count consumed by the downstream threshold comparator, which turns the count into the 100 Hz step clock.
- Also emits a one-cycle tick at each period wrap and a step index 0..STEPS-1 for the sequencer pattern logic.
- Replaces the fixed 500,000-cycle divider with a tempo-loadable, start/stop-controlled source.

Parameters:
- CNT_W, 19, width of count and period registers.
- DEFAULT_PERIOD, 500000, period loaded at reset (50 MHz / 500,000 = 100 Hz).
- MIN_PERIOD, 2, smallest accepted period; smaller loads are clamped to this value.
- STEPS, 16, number of sequencer steps before step wraps.
- STEP_W, 4, width of step index; must satisfy 2^STEP_W >= STEPS.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = timebase counting, 0 = stopped.
- period_in  in  CNT_W  requested period in clk cycles.
- period_load  in  1  one-cycle strobe; captures period_in.
- period_ack  out  1  one-cycle pulse, cycle after period_load.
- count_out  out  CNT_W  current count, 0..active_period-1.
- tick  out  1  one-cycle pulse on the cycle count_out returns to 0.
- step  out  STEP_W  current step index.
- step_wrap  out  1  one-cycle pulse when step returns to 0 (coincides with tick).
- running  out  1  1 while in RUNNING state.

Behaviour:
- Reset values (rst high at a clk edge):
  - count_out=0, step=0, tick=0, step_wrap=0, period_ack=0, running=0.
  - active_period=DEFAULT_PERIOD, shadow_period=DEFAULT_PERIOD, shadow_valid=0, state=STOPPED.
  - Reset overrides all other inputs, including mid-period and mid-load; a load coincident with reset is dropped and not acked.
- States: STOPPED, RUNNING.
  - STOPPED -> RUNNING when run=1. The first RUNNING cycle shows count_out=0, and no tick is issued on entry.
  - RUNNING -> STOPPED when run=0. At the next edge count_out=0 and running=0; step holds its value; tick and step_wrap are 0.
- Counting in RUNNING:
  - count_out increments by 1 each cycle.
  - When count_out==active_period-1, the next edge sets count_out=0, tick=1 and step=(step+1) mod STEPS. step_wrap=1 on that same edge if the new step is 0.
  - tick and step_wrap are registered and high for exactly one cycle.
  - With active_period=P, ticks occur every P cycles and step advances every P cycles.
- Period loading:
  - On period_load=1, shadow_period is set to max(period_in, MIN_PERIOD), shadow_valid=1, and period_ack=1 on the next cycle.
  - Every load is acked. Back-to-back loads overwrite shadow_period; the last one wins.
  - In RUNNING, the shadow is applied only at a wrap edge: active_period<=shadow_period and shadow_valid<=0. This guarantees no truncated or glitched period.
  - A load on the same edge as a wrap lands in the shadow and is applied at the following wrap; that wrap uses the prior active_period.
  - In STOPPED, the shadow is applied on the cycle after capture.
- Boundary conditions:
  - period_in=0 or 1 is clamped to 2, which is the fastest tick (every 2 cycles).
  - period_in=2^CNT_W-1 (524,287) is legal.
  - Counting never exceeds active_period-1, so count_out never wraps through 2^CNT_W.
  - With the default period, count_out crosses 250,000 at mid-period, so the downstream comparator yields a 50% duty 100 Hz clock.
- Timing: all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset with run=0, then hold rst=0 for 10 cycles -> count_out=0, step=0, running=0, tick never asserts; active period 500,000.
2. Load period 5 while stopped, then set run=1 -> period_ack pulses one cycle after the load; count_out runs 0,1,2,3,4,0; tick high on every return to 0 (every 5 cycles); step runs 1,2,3…
3. Period 3, run 48 cycles -> 16 ticks; step goes 0..15 and back to 0; step_wrap pulses exactly once, coincident with the 16th tick.
4. Running at period 6, load period 3 when count_out=2 -> count continues to 5 and wraps; the next period is 3 cycles; one ack. Repeat with the load issued exactly on a wrap edge -> one more period of 6 elapses, then 3.
5. Load period_in=0 -> active period 2 (tick every 2 cycles). Load 524,287 -> count_out reaches 524,286, then returns to 0 with a tick.
6. Set run=0 at count_out=3, step=7 -> next cycle count_out=0, step=7, running=0. Set run=1 again -> counting restarts from 0, with the first tick after a full period. Assert rst at mid-period -> all outputs return to reset values on the next edge.
